// File: rtl/sliding_window_buffer_pkg.sv
// sliding_window_buffer_pkg: default image geometry and window element indexing
package sliding_window_buffer_pkg;
  localparam int DEF_PIXEL_WIDTH = 1;
  localparam int DEF_IMAGE_WIDTH = 7;
  localparam int DEF_IMAGE_HEIGHT = 7;
  localparam int DEF_WINDOW_SIZE = 3;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_ROW_WIDTH = 3;
  function automatic int idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction
endpackage

// File: rtl/sliding_window_buffer_line_ram.sv
// line_ram: single-port line store, combinational read-before-write at one address
module line_ram #(
  parameter int PIXEL_WIDTH = 1,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [PIXEL_WIDTH-1:0] wdata,
  output logic [PIXEL_WIDTH-1:0] rdata
);
  logic [PIXEL_WIDTH-1:0] mem [2**ADDR_WIDTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/sliding_window_buffer.sv
// sliding_window_buffer: raster-scan NxN window generator backed by a cascade of line RAMs
module sliding_window_buffer
  import sliding_window_buffer_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ROW_WIDTH = DEF_ROW_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          clear,
  input  logic                                          in_valid,
  input  logic [PIXEL_WIDTH-1:0]                        in_data,
  output logic                                          out_valid,
  output logic [WINDOW_SIZE*WINDOW_SIZE*PIXEL_WIDTH-1:0] out_window,
  output logic [ADDR_WIDTH-1:0]                         out_col,
  output logic [ROW_WIDTH-1:0]                          out_row,
  output logic                                          frame_done
);
  localparam int N = WINDOW_SIZE;
  localparam int PW = PIXEL_WIDTH;
  logic accept, last_col, last_row, in_window;
  logic [ADDR_WIDTH-1:0] col;
  logic [ROW_WIDTH-1:0] row;
  logic [PW-1:0] rd [N-1];
  logic [PW-1:0] wd [N-1];
  logic [PW-1:0] column [N];
  assign accept = in_valid & ~clear;
  assign last_col = col == ADDR_WIDTH'(IMAGE_WIDTH - 1);
  assign last_row = row == ROW_WIDTH'(IMAGE_HEIGHT - 1);
  assign in_window = col >= ADDR_WIDTH'(N - 1) && row >= ROW_WIDTH'(N - 1);
  assign column[N-1] = in_data;
  genvar k;
  // each RAM hands its old line up to the next-older RAM; the newest RAM takes the incoming pixel
  for (k = 0; k < N - 1; k++) begin : g_ram
    if (k == N - 2) begin : g_top
      assign wd[k] = in_data;
    end else begin : g_mid
      assign wd[k] = rd[k+1];
    end
    assign column[k] = rd[k];
    line_ram #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk(clk), .we(accept), .addr(col), .wdata(wd[k]), .rdata(rd[k])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
      out_valid <= 1'b0;
      out_col <= '0;
      out_row <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
      out_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid <= accept & in_window;
      frame_done <= accept & last_col & last_row;
      if (accept) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) row <= last_row ? '0 : row + 1'b1;
        out_col <= col;
        out_row <= row;
      end
    end
  // element c=N-1 sits at the top of each row slice, so shifting left in c is a right shift
  always_ff @(posedge clk or posedge rst)
    if (rst) out_window <= '0;
    else if (accept)
      for (int r = 0; r < N; r++)
        out_window[idx(r, 0, N)*PW +: N*PW] <= {column[r], out_window[idx(r, 1, N)*PW +: (N-1)*PW]};
endmodule

// File: tb/tb_sliding_window_buffer.sv
// tb_sliding_window_buffer: directed scoreboard bench driving a PW=8 and a PW=1 instance in lockstep
module tb_sliding_window_buffer;
  localparam int N = 3, W = 7, H = 7;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic ov8, ov1, fd8, fd1;
  logic [71:0] win8;
  logic [8:0] win1;
  logic [2:0] oc8, or8, oc1, or1;
  typedef struct packed {
    logic [71:0] w;
    logic [8:0]  w1;
    logic [2:0]  c;
    logic [2:0]  r;
    logic        fd;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, mcol = 0, mrow = 0, nvalid = 0, nfd = 0, nacc = 0, first_valid = -1;
  always #5 clk = ~clk;
  sliding_window_buffer #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .WINDOW_SIZE(N),
    .ADDR_WIDTH(3), .ROW_WIDTH(3)) dut8 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov8), .out_window(win8), .out_col(oc8), .out_row(or8), .frame_done(fd8));
  sliding_window_buffer #(.PIXEL_WIDTH(1), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .WINDOW_SIZE(N),
    .ADDR_WIDTH(3), .ROW_WIDTH(3)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data[0]),
    .out_valid(ov1), .out_window(win1), .out_col(oc1), .out_row(or1), .frame_done(fd1));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic zero_check(input string tag);
    chk({tag, "_valid8"}, ov8, 0);
    chk({tag, "_valid1"}, ov1, 0);
    chk({tag, "_fd8"}, fd8, 0);
    chk({tag, "_fd1"}, fd1, 0);
    chk({tag, "_win8"}, win8, 0);
    chk({tag, "_win1"}, win1, 0);
    chk({tag, "_col"}, oc8, 0);
    chk({tag, "_row"}, or8, 0);
  endtask
  task automatic send(input logic v, input logic clr);
    exp_t e;
    logic pushed;
    logic [7:0] p;
    in_valid = v;
    clear = clr;
    in_data = 8'(mrow * 16 + mcol);
    pushed = 0;
    e = '0;
    if (v && !clr) begin
      nacc++;
      if (mcol >= N - 1 && mrow >= N - 1) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            p = 8'((mrow - 2 + r) * 16 + (mcol - 2 + c));
            e.w[(r*N+c)*8 +: 8] = p;
            e.w1[r*N+c] = p[0];
          end
        e.c = 3'(mcol);
        e.r = 3'(mrow);
        e.fd = (mcol == W - 1 && mrow == H - 1);
        q.push_back(e);
        pushed = 1;
      end
      mcol++;
      if (mcol == W) begin
        mcol = 0;
        mrow = (mrow + 1) % H;
      end
    end
    if (clr) begin
      mcol = 0;
      mrow = 0;
    end
    @(posedge clk);
    #1;
    chk("valid8", ov8, pushed);
    chk("valid1", ov1, pushed);
    if (ov8 && q.size() > 0) begin
      e = q.pop_front();
      chk("win8", win8, e.w);
      chk("win1", win1, e.w1);
      chk("col8", oc8, e.c);
      chk("row8", or8, e.r);
      chk("col1", oc1, e.c);
      chk("row1", or1, e.r);
      chk("fd8", fd8, e.fd);
      chk("fd1", fd1, e.fd);
      nvalid++;
      if (fd8) nfd++;
      if (first_valid < 0) first_valid = nacc - 1;
    end else begin
      chk("fd_idle8", fd8, 0);
      chk("fd_idle1", fd1, 0);
    end
  endtask
  task automatic run_frame(input int gap_pct);
    nvalid = 0;
    nfd = 0;
    for (int i = 0; i < W * H; i++) begin
      if (gap_pct > 0 && (mcol == W - 1 || mcol == 0 || $urandom_range(99) < gap_pct)) send(0, 0);
      send(1, 0);
    end
    chk("frame_valid_count", nvalid, 25);
    chk("frame_done_count", nfd, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    zero_check("reset");
    rst = 0;
    run_frame(0);
    chk("first_valid_index", first_valid, 16);
    run_frame(0);
    run_frame(40);
    while (!(mrow == 3 && mcol == 4)) send(1, 0);
    send(1, 1);
    send(0, 0);
    run_frame(0);
    repeat (20) send(1, 0);
    #2 rst = 1;
    #1 zero_check("async_reset");
    #1 rst = 0;
    mcol = 0;
    mrow = 0;
    q.delete();
    run_frame(0);
    send(0, 0);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
